fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the RV32I pipeline. Generates the PC, issues
//  one-outstanding word reads to instruction memory over a req/ready +
//  rvalid handshake, and loads the fetched word into the Decode register.
//  InstrD[6:0], [14:12] and [30] feed op/funct3/funct7b5 of the control
//  decoder. Takes PCSrcE/PCTargetE back from Execute as the redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address; must be word aligned
//  NOP_INSTR 32'h0000_0013  bubble word (addi x0,x0,0) placed in InstrD
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  StallF       in   1   freeze PC; no new request issued
//  StallD       in   1   hold Decode register contents
//  FlushD       in   1   load bubble into Decode register
//  PCSrcE       in   1   redirect fetch to PCTargetE
//  PCTargetE    in   32  branch/jump target; bits [1:0] ignored (forced 0)
//  imem_req     out  1   read request valid
//  imem_addr    out  32  word address (PCF), [1:0]=0
//  imem_ready   in   1   request accepted this cycle (when imem_req=1)
//  imem_rvalid  in   1   read data valid; earliest 1 cycle after acceptance
//  imem_rdata   in   32  instruction word
//  InstrD       out  32  Decode-stage instruction
//  PCD          out  32  PC of InstrD
//  PCPlus4D     out  32  PCD+4, mod 2^32
//  InstrValidD  out  1   InstrD is a real fetched instruction
// BEHAVIOUR
//  Reset (async): PCF=RESET_PC, state=REQ, imem_req=0 while reset high,
//   InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, InstrValidD=0, hold buffer empty.
//  States: REQ, WAIT, HOLD, DISCARD. Exactly one request outstanding.
//  REQ: imem_req=!StallF, imem_addr=PCF. req&ready -> WAIT.
//   Address may change before acceptance (redirect only).
//  WAIT: on rvalid: if !StallD & !FlushD, load InstrD=rdata, PCD=PCF,
//   PCPlus4D=PCF+4, InstrValidD=1, PCF<=PCF+4, -> REQ. Otherwise capture
//   rdata into hold buffer, -> HOLD.
//  HOLD: when !StallD & !FlushD, load Decode reg from buffer as above, -> REQ.
//  DISCARD: drop next rvalid beat, then -> REQ; no Decode update.
//  Redirect (PCSrcE) has top priority, all states: PCF<=PCTargetE&~3.
//   REQ without acceptance: stay REQ, new address next cycle.
//   REQ with req&ready same cycle: -> DISCARD.
//   WAIT without rvalid: -> DISCARD. WAIT with rvalid: drop data, -> REQ.
//   HOLD: drop buffer, -> REQ. DISCARD with rvalid: -> REQ, else stay.
//   Redirect overrides StallF for PCF update.
//  Decode register priority: reset > FlushD (InstrD=NOP_INSTR,
//   InstrValidD=0, PCD/PCPlus4D unchanged) > StallD (hold) > load.
//  Timing: zero-wait memory gives InstrD update 2 cycles after req
//   (REQ accept edge, rvalid edge); peak throughput 1 instr / 2 cycles.
//  PCF+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no error.
//  Reset mid-transaction: state/regs cleared immediately; a late rvalid
//   after reset release while in REQ is ignored.
//  rvalid outside WAIT/DISCARD is ignored (memory protocol violation).
// TESTING
//  Reset, ready=1, rvalid 1 cycle later, rdata=0x00500093 -> imem_addr
//   0x0,0x4,0x8...; InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4, valid=1.
//  ready held low 3 cycles -> imem_req stays 1, imem_addr constant, InstrD
//   stays NOP, InstrValidD=0.
//  PCSrcE=1, PCTargetE=0x103 while in WAIT -> returning beat dropped; next
//   imem_addr=0x100; InstrD never shows the dropped word.
//  StallD=1 when rvalid arrives -> InstrD held; on StallD=0 buffered word
//   loads, PCF advances exactly once.
//  RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000,
//   PCPlus4D=0x0 for first instruction.
//  reset pulsed in WAIT, then late rvalid -> InstrD=NOP, valid=0,
//   imem_addr=RESET_PC, stray beat ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One word read outstanding at a time: req/ready accepts, rvalid returns the word.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, single-outstanding imem reads, Decode register.
// Redirects from Execute take priority over every fetch state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    fetch_unit_if.master      imem,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              InstrValidD
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, pcd_q, pcp4_q;
    logic        valid_q;

    logic        req;
    logic        accept;
    logic        dec_free;
    logic        load;
    logic [31:0] load_word;
    logic [31:0] target;

    assign accept   = req & imem.ready;
    assign dec_free = !StallD && !FlushD;
    assign target   = PCTargetE & ~32'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            // load is only raised when neither FlushD nor StallD is set, so a stall holds implicitly
            if (FlushD) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (load) begin
                instr_q <= load_word;
                pcd_q   <= pc_q;
                pcp4_q  <= pc_q + 32'd4;
                valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        load      = 1'b0;
        load_word = hold_q;
        unique case (state_q)
            S_REQ: begin
                if (PCSrcE) begin
                    pc_d = target;
                    if (accept) state_d = S_DISCARD;
                end else if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    state_d = imem.rvalid ? S_REQ : S_DISCARD;
                end else if (imem.rvalid) begin
                    if (dec_free) begin
                        load      = 1'b1;
                        load_word = imem.rdata;
                        pc_d      = pc_q + 32'd4;
                        state_d   = S_REQ;
                    end else begin
                        hold_d  = imem.rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (dec_free) begin
                    load    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (PCSrcE) pc_d = target;
                if (imem.rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        req         = (state_q == S_REQ) && !StallF && !reset;
        imem.req    = req;
        imem.addr   = pc_q;
        InstrD      = instr_q;
        PCD         = pcd_q;
        PCPlus4D    = pcp4_q;
        InstrValidD = valid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable imem responder plus hand-computed
// expectations; a second instance covers the top-of-address-space reset PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        InstrValidD;
    logic [31:0] InstrD2, PCD2, PCPlus4D2;
    logic        InstrValidD2;
    logic        ready_en;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit_if ifc ();
    fetch_unit_if ifc2 ();

    fetch_unit dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(ifc),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut2 (
        .clk(clk), .reset(reset), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'h0), .imem(ifc2),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .InstrValidD(InstrValidD2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h0050_0093 | {a[15:0], 16'h0000};
    endfunction

    // Responder for dut: word returns lat cycles after acceptance
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    assign ifc.ready = ready_en;
    always @(posedge clk) begin
        if (ifc.req && ifc.ready) begin
            cnt   = lat;
            paddr = ifc.addr;
        end
        #1;
        ifc.rvalid = 1'b0;
        if (cnt == 1) begin
            ifc.rvalid = 1'b1;
            ifc.rdata  = memword(paddr);
        end
        if (cnt > 0) cnt--;
    end

    // Zero-wait responder for dut2
    logic        acc2;
    logic [31:0] paddr2;
    assign ifc2.ready = 1'b1;
    always @(posedge clk) begin
        acc2   = ifc2.req && ifc2.ready;
        paddr2 = ifc2.addr;
        #1;
        ifc2.rvalid = acc2;
        ifc2.rdata  = memword(paddr2);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] i, input logic [31:0] p,
                             input logic [31:0] p4, input logic v);
        check({tag, "_instr"}, InstrD, i);
        check({tag, "_pcd"}, PCD, p);
        check({tag, "_pcp4"}, PCPlus4D, p4);
        check({tag, "_valid"}, 32'(InstrValidD), 32'(v));
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; ready_en = 1'b0;
        repeat (2) tick();
        check("rst_req", 32'(ifc.req), 32'd0);
        check("rst_addr", ifc.addr, 32'h0);
        check_dec("rst", 32'h13, 32'h0, 32'h0, 1'b0);
        check("rst2_addr", ifc2.addr, 32'hFFFF_FFFC);
        check("rst2_req", 32'(ifc2.req), 32'd0);

        // Memory not ready: request held steady, Decode stays a bubble
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nrdy_req", 32'(ifc.req), 32'd1);
            check("nrdy_addr", ifc.addr, 32'h0);
            check("nrdy_instr", InstrD, 32'h13);
            check("nrdy_valid", 32'(InstrValidD), 32'd0);
        end
        // dut2 wraps its PC from 0xFFFF_FFFC to 0
        check("wrap_instr", InstrD2, 32'hFFFC_0093);
        check("wrap_pcd", PCD2, 32'hFFFF_FFFC);
        check("wrap_pcp4", PCPlus4D2, 32'h0);
        check("wrap_valid", 32'(InstrValidD2), 32'd1);
        check("wrap_addr", ifc2.addr, 32'h0);

        // Zero-wait fetch stream
        ready_en = 1'b1;
        tick();
        check("f0_req", 32'(ifc.req), 32'd0);
        check("f0_instr", InstrD, 32'h13);
        tick();
        check_dec("f0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("f1_addr", ifc.addr, 32'h4);
        check("f1_req", 32'(ifc.req), 32'd1);
        tick(); tick();
        check_dec("f1", 32'h0054_0093, 32'h4, 32'h8, 1'b1);
        check("f2_addr", ifc.addr, 32'h8);

        // StallF suppresses the request
        StallF = 1'b1;
        tick();
        check("stf_req", 32'(ifc.req), 32'd0);
        check("stf_addr", ifc.addr, 32'h8);
        StallF = 1'b0;

        // Redirect while waiting: in-flight word is dropped
        lat = 3;
        tick();
        check("rdw_req", 32'(ifc.req), 32'd0);
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        tick();
        PCSrcE = 1'b0;
        check("rdw_disc_req", 32'(ifc.req), 32'd0);
        check("rdw_addr", ifc.addr, 32'h100);
        tick();
        check("rdw_disc2_req", 32'(ifc.req), 32'd0);
        tick();
        check("rdw_back_req", 32'(ifc.req), 32'd1);
        check("rdw_back_addr", ifc.addr, 32'h100);
        check_dec("rdw_drop", 32'h0054_0093, 32'h4, 32'h8, 1'b1);
        lat = 1;
        tick(); tick();
        check_dec("rdw_new", 32'h0150_0093, 32'h100, 32'h104, 1'b1);
        check("rdw_next_addr", ifc.addr, 32'h104);

        // StallD when the word arrives: buffered, then loaded once
        StallD = 1'b1;
        tick(); tick();
        check("std_instr", InstrD, 32'h0150_0093);
        check("std_req", 32'(ifc.req), 32'd0);
        tick();
        check("std2_instr", InstrD, 32'h0150_0093);
        check("std2_addr", ifc.addr, 32'h104);
        StallD = 1'b0;
        tick();
        check_dec("std_load", 32'h0154_0093, 32'h104, 32'h108, 1'b1);
        check("std_addr", ifc.addr, 32'h108);
        check("std_req1", 32'(ifc.req), 32'd1);
        tick();
        check("std_once_addr", ifc.addr, 32'h108);
        tick();
        check_dec("std_next", 32'h0158_0093, 32'h108, 32'h10C, 1'b1);

        // FlushD: bubble inserted, PCD kept; word waits in buffer until flush lifts
        FlushD = 1'b1;
        tick();
        check_dec("fl", 32'h13, 32'h108, 32'h10C, 1'b0);
        tick();
        check("fl2_instr", InstrD, 32'h13);
        check("fl2_req", 32'(ifc.req), 32'd0);
        FlushD = 1'b0;
        tick();
        check_dec("fl_load", 32'h015C_0093, 32'h10C, 32'h110, 1'b1);
        check("fl_addr", ifc.addr, 32'h110);

        // Reset while waiting, then a stray beat after release
        lat = 3;
        tick();
        reset = 1'b1;
        #1;
        check_dec("mrst", 32'h13, 32'h0, 32'h0, 1'b0);
        check("mrst_addr", ifc.addr, 32'h0);
        check("mrst_req", 32'(ifc.req), 32'd0);
        ready_en = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("stray_instr", InstrD, 32'h13);
        check("stray_valid", 32'(InstrValidD), 32'd0);
        check("stray_addr", ifc.addr, 32'h0);
        check("stray_req", 32'(ifc.req), 32'd1);
        lat = 1; ready_en = 1'b1;
        tick(); tick();
        check_dec("post", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
